frame_capture_stream: RTL and testbench
=======================================

FRAME_CAPTURE_STREAM -- requirements
Module: frame_capture_stream

Interface
REQ-001 SHALL have parameter COLOR_W, default 8: bits per colour channel.
REQ-002 SHALL have parameter H_START, default 144: first active iH_CNT value.
REQ-003 SHALL have parameter V_START, default 35: first active iV_CNT value.
REQ-004 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-005 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-006 SHALL have parameter DECIM, default 1: keep every DECIM-th pixel in x and in y (legal 1..8).
REQ-007 SHALL have parameter FIFO_DEPTH, default 16: output buffer entries (power of two, >=2).
REQ-008 SHALL have port iCLK  in  1: single clock (pixel clock); all logic on rising edge.
REQ-009 SHALL have port iRST_N  in  1: reset, asynchronous, active-low.
REQ-010 SHALL have ports iRED, iGREEN, iBLUE  in  COLOR_W each: current pixel colour.
REQ-011 SHALL have ports iH_CNT, iV_CNT  in  12 each: timing-generator counters, (0,0) = frame start.
REQ-012 SHALL have port iARM  in  1: one-cycle request to capture the next full frame.
REQ-013 SHALL have port oBUSY  out  1: high in any state except IDLE.
REQ-014 SHALL have port oDATA  out  DW: captured word, DW = 3*COLOR_W (+24 with REQ-031).
REQ-015 SHALL have ports oVALID out 1, iREADY in 1: stream handshake; transfer when both high.
REQ-016 SHALL have port oOVERFLOW  out  1: sticky, a pixel was dropped on full FIFO.
REQ-017 SHALL have port oDONE  out  1: one-cycle pulse when capture fully drained.

Function
REQ-018 SHALL implement FSM IDLE -> ARMED (iARM in IDLE) -> CAPTURE (iH_CNT==0 and iV_CNT==0) -> DRAIN (cycle after last active pixel H_START+H_ACTIVE-1, V_START+V_ACTIVE-1) -> IDLE (FIFO empty).
REQ-019 SHALL ignore iARM outside IDLE; arming mid-frame waits for the next (0,0).
REQ-020 SHALL in CAPTURE push a pixel iff counters are inside the active window and (iH_CNT-H_START) mod DECIM == 0 and (iV_CNT-V_START) mod DECIM == 0, using internal x/y phase counters, not dividers.
REQ-021 SHALL pack oDATA as {R,G,B}, R in MSBs, in raster order.
REQ-022 SHALL present a pushed word on oDATA no earlier than the next cycle (registered FIFO output).
REQ-023 SHALL hold oDATA and oVALID stable while oVALID high and iREADY low.
REQ-024 SHALL accept a push when FIFO full only if a pop occurs in the same cycle; otherwise drop the pixel and set oOVERFLOW.
REQ-025 SHALL clear oOVERFLOW only when iARM is accepted in IDLE.
REQ-026 SHALL assert oDONE for exactly one cycle on the DRAIN -> IDLE transition.
REQ-027 SHALL keep draining in DRAIN with no further pushes; iREADY low indefinitely stalls DRAIN.

Reset
REQ-028 SHALL on iRST_N low, asynchronously: state IDLE, FIFO empty, oVALID=0, oDATA=0, oBUSY=0, oOVERFLOW=0, oDONE=0.
REQ-029 SHALL on reset mid-capture discard all buffered words; no oDONE is emitted.
REQ-030 SHALL leave reset synchronously to iCLK; first iARM honoured the cycle after release.

Configuration
REQ-031 SHALL with FRAME_CAPTURE_COORD_EN defined prepend {x[11:0], y[11:0]} (x = iH_CNT-H_START, y = iV_CNT-V_START) to each word, DW = 3*COLOR_W+24; without it DW = 3*COLOR_W, no coordinate logic.

Verification
REQ-032 SHALL cover: H_ACTIVE=4, V_ACTIVE=2, DECIM=1, iREADY=1, arm -> 8 words raster order, oDONE one cycle after last transfer, oOVERFLOW=0.
REQ-033 SHALL cover: FIFO_DEPTH=4, iREADY=0 through 8 active pixels -> first 4 pixels held, oOVERFLOW=1; iREADY=1 -> exactly 4 words then oDONE.
REQ-034 SHALL cover: 4x4 window, DECIM=2 -> 4 words for pixels (0,0),(2,0),(0,2),(2,2).
REQ-035 SHALL cover: iARM at (2,1) mid-frame -> state ARMED, first word is pixel (0,0) of next frame; second iARM during CAPTURE has no effect.
REQ-036 SHALL cover: iRST_N low during CAPTURE with 3 words buffered -> oVALID=0, oBUSY=0 same cycle, no oDONE after release.
REQ-037 SHALL cover: FRAME_CAPTURE_COORD_EN defined, pixel x=3, y=1 -> upper 24 bits of oDATA = 0x003001.

Source files
------------

// File: rtl/frame_capture_stream.sv
// Single-frame pixel capture into a stream FIFO with optional x/y decimation.
// Define FRAME_CAPTURE_COORD_EN to prepend {x[11:0], y[11:0]} to every captured word.
module frame_capture_stream #(
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned H_START    = 144,
  parameter int unsigned V_START    = 35,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned DECIM      = 1,
  parameter int unsigned FIFO_DEPTH = 16,
`ifdef FRAME_CAPTURE_COORD_EN
  localparam int unsigned DW = 3 * COLOR_W + 24
`else
  localparam int unsigned DW = 3 * COLOR_W
`endif
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [COLOR_W-1:0] iRED,
  input  logic [COLOR_W-1:0] iGREEN,
  input  logic [COLOR_W-1:0] iBLUE,
  input  logic [11:0]        iH_CNT,
  input  logic [11:0]        iV_CNT,
  input  logic               iARM,
  output logic               oBUSY,
  output logic [DW-1:0]      oDATA,
  output logic               oVALID,
  input  logic               iREADY,
  output logic               oOVERFLOW,
  output logic               oDONE
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [11:0] H_FIRST = 12'(H_START);
  localparam logic [11:0] H_LAST  = 12'(H_START + H_ACTIVE - 1);
  localparam logic [11:0] V_FIRST = 12'(V_START);
  localparam logic [11:0] V_LAST  = 12'(V_START + V_ACTIVE - 1);
  localparam logic [2:0]  PH_LAST = 3'(DECIM - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t        state, state_next;
  logic          busy_next, done_next, ovf_next;

  logic [2:0]    x_ph, y_ph, x_cur_c, y_cur_c;
  logic          in_h_c, in_v_c, keep_c, last_px_c, frame_start_c;
  logic          push_req_c, push_c, pop_c, full_c, drop_c;

  logic [AW-1:0] wr_ptr, rd_ptr, rd_next_c;
  logic [CW-1:0] count, count_next_c, remain_c;
  logic [DW-1:0] pix_c, head_c;
  logic [DW-1:0] mem [FIFO_DEPTH];

  // Incoming word, optionally tagged with its window-relative coordinates
`ifdef FRAME_CAPTURE_COORD_EN
  logic [11:0] x_c, y_c;
  always_comb begin
    x_c   = iH_CNT - H_FIRST;
    y_c   = iV_CNT - V_FIRST;
    pix_c = {x_c, y_c, iRED, iGREEN, iBLUE};
  end
`else
  always_comb begin
    pix_c = {iRED, iGREEN, iBLUE};
  end
`endif

  // Window decode; phase counters restart at the first pixel/line of the window
  always_comb begin
    in_h_c        = (iH_CNT >= H_FIRST) && (iH_CNT <= H_LAST);
    in_v_c        = (iV_CNT >= V_FIRST) && (iV_CNT <= V_LAST);
    x_cur_c       = (iH_CNT == H_FIRST) ? 3'd0 : x_ph;
    y_cur_c       = (iV_CNT == V_FIRST) ? 3'd0 : y_ph;
    keep_c        = in_h_c && in_v_c && (x_cur_c == 3'd0) && (y_cur_c == 3'd0);
    last_px_c     = (iH_CNT == H_LAST) && (iV_CNT == V_LAST);
    frame_start_c = (iH_CNT == 12'd0) && (iV_CNT == 12'd0);
    push_req_c    = (state == S_CAPTURE) && keep_c;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x_ph <= 3'd0;
      y_ph <= 3'd0;
    end else begin
      if (in_h_c && in_v_c)
        x_ph <= (x_cur_c == PH_LAST) ? 3'd0 : x_cur_c + 3'd1;
      if (in_v_c && (iH_CNT == H_LAST))
        y_ph <= (y_cur_c == PH_LAST) ? 3'd0 : y_cur_c + 3'd1;
    end
  end

  // FIFO control; a full FIFO still accepts when the head leaves the same cycle
  always_comb begin
    pop_c        = oVALID && iREADY;
    full_c       = (count == FULL_CNT);
    push_c       = push_req_c && (!full_c || pop_c);
    drop_c       = push_req_c && !push_c;
    count_next_c = count + CW'(push_c) - CW'(pop_c);
    remain_c     = count - CW'(pop_c);
    rd_next_c    = rd_ptr + AW'(pop_c);
    head_c       = (remain_c == '0) ? pix_c : mem[rd_next_c];
  end

  always_ff @(posedge iCLK) begin
    if (push_c)
      mem[wr_ptr] <= pix_c;
  end

  // oDATA/oVALID mirror the head entry, so the output register counts toward capacity
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      oVALID <= 1'b0;
      oDATA  <= '0;
    end else begin
      if (push_c)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next_c;
      count  <= count_next_c;
      oVALID <= (count_next_c != '0);
      if (count_next_c != '0)
        oDATA <= head_c;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= S_IDLE;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
      oOVERFLOW <= 1'b0;
    end else begin
      state     <= state_next;
      oBUSY     <= busy_next;
      oDONE     <= done_next;
      oOVERFLOW <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    ovf_next   = oOVERFLOW || drop_c;
    case (state)
      S_IDLE: begin
        if (iARM) begin
          state_next = S_ARMED;
          ovf_next   = 1'b0;
        end
      end
      S_ARMED: begin
        if (frame_start_c)
          state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (last_px_c)
          state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (count == '0) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    busy_next = (state_next != S_IDLE);
  end

endmodule

// File: tb/tb_frame_capture_stream.sv
// Randomized-pixel bench for frame_capture_stream: a frame-level reference model
// predicts the captured word list for a small timing raster.
module tb_frame_capture_stream;

  localparam int unsigned COLOR_W = 8;
`ifdef FRAME_CAPTURE_COORD_EN
  localparam int unsigned DW = 3 * COLOR_W + 24;
`else
  localparam int unsigned DW = 3 * COLOR_W;
`endif
  localparam int H_START = 2;
  localparam int V_START = 1;
  localparam int H_TOT   = 8;
  localparam int V_TOT   = 6;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic          iRST_N;
  logic [7:0]    red, green, blue;
  logic [11:0]   h_cnt, v_cnt;
  logic          arm, ready;

  logic          a_busy, a_valid, a_ovf, a_done;
  logic [DW-1:0] a_data;
  logic          b_busy, b_valid, b_ovf, b_done;
  logic [DW-1:0] b_data;

  int unsigned   seeds [2048];
  int            frame_cnt;
  int            compares, errors;
  int            smp_n, a_done_cnt, b_done_cnt, a_done_n, a_last_xfer;
  logic [DW-1:0] a_q [$];
  logic [DW-1:0] b_q [$];

  frame_capture_stream #(
    .COLOR_W(COLOR_W), .H_START(H_START), .V_START(V_START),
    .H_ACTIVE(4), .V_ACTIVE(2), .DECIM(1), .FIFO_DEPTH(4)
  ) u_dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iRED(red), .iGREEN(green), .iBLUE(blue),
    .iH_CNT(h_cnt), .iV_CNT(v_cnt), .iARM(arm), .oBUSY(a_busy), .oDATA(a_data),
    .oVALID(a_valid), .iREADY(ready), .oOVERFLOW(a_ovf), .oDONE(a_done)
  );

  frame_capture_stream #(
    .COLOR_W(COLOR_W), .H_START(H_START), .V_START(V_START),
    .H_ACTIVE(4), .V_ACTIVE(4), .DECIM(2), .FIFO_DEPTH(8)
  ) u_dec (
    .iCLK(iCLK), .iRST_N(iRST_N), .iRED(red), .iGREEN(green), .iBLUE(blue),
    .iH_CNT(h_cnt), .iV_CNT(v_cnt), .iARM(arm), .oBUSY(b_busy), .oDATA(b_data),
    .oVALID(b_valid), .iREADY(ready), .oOVERFLOW(b_ovf), .oDONE(b_done)
  );

  // Pixel colour is a hash of the frame's random seed and the raster position
  function automatic logic [23:0] pix(int unsigned s, int h, int v);
    logic [31:0] t;
    t = s ^ (32'(h) * 32'h9E37_79B1) ^ (32'(v) * 32'h85EB_CA6B);
    t = t ^ (t >> 15);
    return t[23:0];
  endfunction

  function automatic logic [DW-1:0] exp_word(int f, int x, int y);
    logic [23:0] p;
    p = pix(seeds[f], x + H_START, y + V_START);
`ifdef FRAME_CAPTURE_COORD_EN
    return {12'(x), 12'(y), p};
`else
    return p;
`endif
  endfunction

  // Timing generator: counters advance 1 time unit after each rising edge
  initial begin
    h_cnt = 12'd0;
    v_cnt = 12'd0;
    frame_cnt = 0;
    seeds[0] = $urandom;
    {red, green, blue} = pix(seeds[0], 0, 0);
    forever begin
      @(posedge iCLK);
      #1;
      if (h_cnt == 12'(H_TOT - 1)) begin
        h_cnt = 12'd0;
        v_cnt = (v_cnt == 12'(V_TOT - 1)) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt = h_cnt + 12'd1;
      end
      if (h_cnt == 12'd0 && v_cnt == 12'd0) begin
        frame_cnt++;
        seeds[frame_cnt] = $urandom;
      end
      {red, green, blue} = pix(seeds[frame_cnt], int'(h_cnt), int'(v_cnt));
    end
  end

  // Transfer/done recorder; ready only changes after a rising edge, so this sample is the handshake
  initial begin
    smp_n = 0;
    forever begin
      @(negedge iCLK);
      smp_n++;
      if (a_valid && ready) begin a_q.push_back(a_data); a_last_xfer = smp_n; end
      if (b_valid && ready) b_q.push_back(b_data);
      if (a_done) begin a_done_cnt++; a_done_n = smp_n; end
      if (b_done) b_done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge iCLK); #2; end
  endtask

  task automatic smp();
    @(negedge iCLK); #1;
  endtask

  task automatic clear_obs();
    a_q.delete(); b_q.delete();
    a_done_cnt = 0; b_done_cnt = 0; a_done_n = -1; a_last_xfer = -1;
  endtask

  task automatic do_reset();
    iRST_N = 1'b0; arm = 1'b0;
    tick(2);
    @(negedge iCLK);
    iRST_N = 1'b1;
    clear_obs();
    tick(1);
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(1); arm = 1'b0;
  endtask

  task automatic wait_pos(int f, int h, int v, int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (frame_cnt == f && int'(h_cnt) == h && int'(v_cnt) == v) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_done(bit use_b, int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      smp();
      if ((use_b ? b_done_cnt : a_done_cnt) > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    iRST_N = 1'b0; arm = 1'b0; ready = 1'b0;
    tick(3);
    smp();
    compares++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    compares++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    compares++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", a_ovf); end
    compares++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
    compares++; if (a_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", a_data); end
    compares++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b want 0", b_valid); end
    @(negedge iCLK);
    iRST_N = 1'b1;
    clear_obs();
    tick(1);
  endtask

  task automatic test_basic();
    int f;
    bit ok;
    logic [DW-1:0] w;
    do_reset();
    ready = 1'b1;
    f = frame_cnt + 1;
    pulse_arm();
    smp();
    compares++; if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", a_busy); end
    wait_done(1'b0, 300, ok);
    compares++; if (!ok) begin errors++; $display("FAIL basic_done_seen: got 0 want 1"); end
    compares++; if (a_q.size() != 8) begin errors++; $display("FAIL basic_count: got %0d want 8", a_q.size()); end
    for (int i = 0; i < 8 && i < a_q.size(); i++) begin
      compares++;
      if (a_q[i] !== exp_word(f, i % 4, i / 4))
        begin errors++; $display("FAIL basic_word%0d: got %h want %h", i, a_q[i], exp_word(f, i % 4, i / 4)); end
    end
    compares++; if (a_done_n != a_last_xfer + 2) begin errors++; $display("FAIL basic_done_timing: got sample %0d want %0d", a_done_n, a_last_xfer + 2); end
    compares++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", a_ovf); end
`ifdef FRAME_CAPTURE_COORD_EN
    if (a_q.size() >= 8) begin
      w = a_q[7];
      compares++; if (w[DW-1 -: 24] !== 24'h003001) begin errors++; $display("FAIL coord_x3_y1: got %h want 003001", w[DW-1 -: 24]); end
    end
`else
    w = '0;
`endif
    smp(); smp();
    compares++; if (a_done !== 1'b0 || a_done_cnt != 1) begin errors++; $display("FAIL basic_done_pulse: got done=%b pulses=%0d want 0/1", a_done, a_done_cnt); end
    compares++; if (a_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", a_busy); end
  endtask

  task automatic test_decim();
    int f;
    bit ok;
    do_reset();
    ready = 1'b1;
    f = frame_cnt + 1;
    pulse_arm();
    wait_done(1'b1, 300, ok);
    compares++; if (!ok) begin errors++; $display("FAIL decim_done_seen: got 0 want 1"); end
    compares++; if (b_q.size() != 4) begin errors++; $display("FAIL decim_count: got %0d want 4", b_q.size()); end
    for (int i = 0; i < 4 && i < b_q.size(); i++) begin
      compares++;
      if (b_q[i] !== exp_word(f, (i % 2) * 2, (i / 2) * 2))
        begin errors++; $display("FAIL decim_word%0d: got %h want %h", i, b_q[i], exp_word(f, (i % 2) * 2, (i / 2) * 2)); end
    end
    compares++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL decim_ovf: got %b want 0", b_ovf); end
  endtask

  task automatic test_overflow();
    int f;
    bit ok, prev_stall;
    logic [DW-1:0] prev_data;
    do_reset();
    ready = 1'b0;
    f = frame_cnt + 1;
    pulse_arm();
    wait_pos(f, 0, V_START + 2, 300, ok);
    compares++; if (!ok) begin errors++; $display("FAIL ovf_reach_end: got 0 want 1"); end
    for (int i = 0; i < 3; i++) begin
      smp();
      compares++;
      if (a_valid !== 1'b1 || a_data !== exp_word(f, 0, 0))
        begin errors++; $display("FAIL ovf_hold%0d: got v=%b d=%h want v=1 d=%h", i, a_valid, a_data, exp_word(f, 0, 0)); end
    end
    compares++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", a_ovf); end
    compares++; if (a_busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b want 1", a_busy); end
    prev_stall = 1'b0;
    prev_data  = '0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      ready = 1'($urandom_range(0, 1));
      smp();
      if (prev_stall) begin
        compares++;
        if (a_valid !== 1'b1 || a_data !== prev_data)
          begin errors++; $display("FAIL ovf_stall_stable: got v=%b d=%h want v=1 d=%h", a_valid, a_data, prev_data); end
      end
      prev_stall = a_valid && !ready;
      prev_data  = a_data;
      if (a_done_cnt > 0) begin ok = 1'b1; break; end
    end
    compares++; if (!ok) begin errors++; $display("FAIL ovf_done_seen: got 0 want 1"); end
    compares++; if (a_q.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d want 4", a_q.size()); end
    for (int i = 0; i < 4 && i < a_q.size(); i++) begin
      compares++;
      if (a_q[i] !== exp_word(f, i, 0))
        begin errors++; $display("FAIL ovf_word%0d: got %h want %h", i, a_q[i], exp_word(f, i, 0)); end
    end
    compares++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", a_ovf); end
    tick(1);
    pulse_arm();
    smp();
    compares++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_arm: got %b want 0", a_ovf); end
  endtask

  task automatic test_mid_arm();
    int f;
    bit ok, stray;
    do_reset();
    ready = 1'b1;
    wait_pos(frame_cnt + ((int'(v_cnt) > V_START + 1) ? 1 : 0), H_START + 2, V_START + 1, 200, ok);
    compares++; if (!ok) begin errors++; $display("FAIL mid_reach_pos: got 0 want 1"); end
    f = frame_cnt + 1;
    pulse_arm();
    smp();
    compares++; if (a_busy !== 1'b1 || a_valid !== 1'b0) begin errors++; $display("FAIL mid_armed: got busy=%b valid=%b want 1/0", a_busy, a_valid); end
    wait_pos(f, H_START + 1, V_START + 1, 200, ok);
    compares++; if (!ok) begin errors++; $display("FAIL mid_reach_capture: got 0 want 1"); end
    pulse_arm();
    wait_done(1'b0, 300, ok);
    compares++; if (!ok) begin errors++; $display("FAIL mid_done_seen: got 0 want 1"); end
    compares++; if (a_q.size() != 8) begin errors++; $display("FAIL mid_count: got %0d want 8", a_q.size()); end
    for (int i = 0; i < 8 && i < a_q.size(); i++) begin
      compares++;
      if (a_q[i] !== exp_word(f, i % 4, i / 4))
        begin errors++; $display("FAIL mid_word%0d: got %h want %h", i, a_q[i], exp_word(f, i % 4, i / 4)); end
    end
    stray = 1'b0;
    for (int i = 0; i < 60; i++) begin
      smp();
      if (a_busy !== 1'b0) stray = 1'b1;
    end
    compares++; if (stray) begin errors++; $display("FAIL mid_second_arm_ignored: got busy after done want idle"); end
    compares++; if (a_done_cnt != 1) begin errors++; $display("FAIL mid_done_pulses: got %0d want 1", a_done_cnt); end
  endtask

  task automatic test_reset_mid();
    int f;
    bit ok;
    do_reset();
    ready = 1'b0;
    f = frame_cnt + 1;
    pulse_arm();
    wait_pos(f, H_START + 3, V_START, 200, ok);
    compares++; if (!ok) begin errors++; $display("FAIL rstmid_reach_pos: got 0 want 1"); end
    smp();
    compares++; if (a_valid !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got valid=%b busy=%b want 1/1", a_valid, a_busy); end
    iRST_N = 1'b0;
    #1;
    compares++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", a_valid); end
    compares++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
    tick(2);
    @(negedge iCLK);
    iRST_N = 1'b1;
    clear_obs();
    tick(1);
    ready = 1'b1;
    repeat (120) smp();
    compares++; if (a_done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", a_done_cnt); end
    compares++; if (a_q.size() != 0) begin errors++; $display("FAIL rstmid_no_words: got %0d want 0", a_q.size()); end
    compares++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b want 0", a_busy); end
  endtask

  initial begin
    compares = 0;
    errors   = 0;
    iRST_N   = 1'b0;
    arm      = 1'b0;
    ready    = 1'b0;
    clear_obs();
    test_reset();
    test_basic();
    test_decim();
    test_overflow();
    test_mid_arm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
